// File: rtl/uart_hex_line_pkg.sv
// ----------------------------------------------------------------------------
// uart_hex_line_pkg
//   Shared definitions for the UART hex line tokenizer: FSM state encoding,
//   the ASCII control characters the classifier reacts to, and the digit
//   counter saturation helper.
// ----------------------------------------------------------------------------
package uart_hex_line_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        POP     = 3'd2,
        ECHO    = 3'd3,
        ECHO_LF = 3'd4,
        EMIT    = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    // A token holds at most eight nibbles; further digits push the oldest out.
    localparam int unsigned MAX_DIGITS = 8;

    function automatic logic [3:0] digit_count_inc(input logic [3:0] cnt);
        return (cnt >= 4'(MAX_DIGITS)) ? 4'(MAX_DIGITS) : cnt + 4'd1;
    endfunction

endpackage

// File: rtl/uart_hex_line_hex_nibble_dec.sv
// ----------------------------------------------------------------------------
// hex_nibble_dec
//   Combinational ASCII hex digit decoder.
//   Ports:
//     data_in : ASCII byte to decode
//     nibble  : value 0-15 of the digit (0 when not a hex digit)
//     is_hex  : 1 for '0'-'9', 'A'-'F', 'a'-'f'
// ----------------------------------------------------------------------------
module hex_nibble_dec (
    input  logic [7:0] data_in,
    output logic [3:0] nibble,
    output logic       is_hex
);

    always_comb begin
        nibble = '0;
        is_hex = 1'b0;
        if (data_in >= 8'h30 && data_in <= 8'h39) begin
            is_hex = 1'b1;
            nibble = data_in[3:0];
        end else if ((data_in >= 8'h41 && data_in <= 8'h46) ||
                     (data_in >= 8'h61 && data_in <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15.
            is_hex = 1'b1;
            nibble = data_in[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/uart_hex_line.sv
// ----------------------------------------------------------------------------
// uart_hex_line
//   Pulls bytes from an rx FIFO, optionally echoes them to a tx FIFO (CR is
//   echoed as CR LF), and accumulates ASCII hex digits into 32-bit tokens.
//   Space ends a token (if it has digits), CR ends a token and the line.
//   Illegal characters set a sticky line error reported on every token of
//   the line.
//   Ports:
//     clk, rst                  : clock, async active-high reset
//     rx_fifo_dvalid, rx_rdata  : rx FIFO not-empty flag and head byte
//     rx_rden                   : one-cycle rx pop
//     tx_fifo_full              : tx FIFO cannot accept a byte
//     tx_wdata, tx_wten         : echo byte and one-cycle tx push
//     tok_data/last/err/nodig   : token payload, held while tok_valid
//     tok_valid, tok_ready      : token handshake
// ----------------------------------------------------------------------------
module uart_hex_line
    import uart_hex_line_pkg::*;
#(
    parameter bit ECHO_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_fifo_dvalid,
    input  logic [7:0]  rx_rdata,
    output logic        rx_rden,
    input  logic        tx_fifo_full,
    output logic [7:0]  tx_wdata,
    output logic        tx_wten,
    output logic [31:0] tok_data,
    output logic        tok_valid,
    input  logic        tok_ready,
    output logic        tok_last,
    output logic        tok_err,
    output logic        tok_nodig
);

    state_t      state;
    logic [7:0]  cur_byte;
    logic [31:0] acc;
    logic [3:0]  dig_cnt;
    logic        line_err;

    // Classification inputs: without echo the byte is classified in POP,
    // straight from the FIFO head, before cur_byte has been loaded.
    logic [7:0]  cls_byte;
    logic [3:0]  cls_nibble;
    logic        cls_is_hex;
    logic        cls_go;
    logic        cls_emit;
    logic        cls_last;
    logic        cls_bad;

    assign cls_byte = (state == POP) ? rx_rdata : cur_byte;

    hex_nibble_dec u_dec (
        .data_in (cls_byte),
        .nibble  (cls_nibble),
        .is_hex  (cls_is_hex)
    );

    // The push strobe is qualified by the live full flag so a push can never
    // coincide with full, even if full rises in the same cycle.
    assign tx_wten = ((state == ECHO) || (state == ECHO_LF)) && !tx_fifo_full;

    // Cycle in which the current byte is classified and the FSM leaves the
    // pop/echo path.
    always_comb begin
        cls_go = 1'b0;
        case (state)
            POP:     cls_go = !ECHO_EN;
            ECHO:    cls_go = !tx_fifo_full && (cur_byte != ASCII_CR);
            ECHO_LF: cls_go = !tx_fifo_full;
            default: cls_go = 1'b0;
        endcase
    end

    always_comb begin
        cls_emit = 1'b0;
        cls_last = 1'b0;
        cls_bad  = 1'b0;
        if (cls_is_hex) begin
            cls_emit = 1'b0;
        end else if (cls_byte == ASCII_SP) begin
            cls_emit = (dig_cnt != 4'd0);
        end else if (cls_byte == ASCII_CR) begin
            cls_emit = 1'b1;
            cls_last = 1'b1;
        end else if (cls_byte == ASCII_LF) begin
            cls_emit = 1'b0;
        end else begin
            cls_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_byte  <= '0;
            acc       <= '0;
            dig_cnt   <= '0;
            line_err  <= 1'b0;
            rx_rden   <= 1'b0;
            tx_wdata  <= '0;
            tok_valid <= 1'b0;
            tok_data  <= '0;
            tok_last  <= 1'b0;
            tok_err   <= 1'b0;
            tok_nodig <= 1'b0;
        end else begin
            rx_rden <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_fifo_dvalid) begin
                        state <= SETTLE;
                    end
                end

                SETTLE: begin
                    // The pop strobe is registered, so it is launched here
                    // and is high exactly for the POP cycle.
                    if (rx_fifo_dvalid) begin
                        state   <= POP;
                        rx_rden <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end

                POP: begin
                    cur_byte <= rx_rdata;
                    if (ECHO_EN) begin
                        state    <= ECHO;
                        tx_wdata <= rx_rdata;
                    end
                end

                ECHO: begin
                    if (!tx_fifo_full && cur_byte == ASCII_CR) begin
                        state    <= ECHO_LF;
                        tx_wdata <= ASCII_LF;
                    end
                end

                ECHO_LF: begin
                    // Leaves through the classify path below.
                end

                EMIT: begin
                    if (tok_ready) begin
                        state     <= IDLE;
                        tok_valid <= 1'b0;
                        tok_data  <= '0;
                        tok_last  <= 1'b0;
                        tok_err   <= 1'b0;
                        tok_nodig <= 1'b0;
                        acc       <= '0;
                        dig_cnt   <= '0;
                        if (tok_last) begin
                            line_err <= 1'b0;
                        end
                    end
                end

                default: state <= IDLE;
            endcase

            // Classification overrides the next state chosen above.
            if (cls_go) begin
                state <= cls_emit ? EMIT : IDLE;
                if (cls_is_hex) begin
                    acc     <= {acc[27:0], cls_nibble};
                    dig_cnt <= digit_count_inc(dig_cnt);
                end
                if (cls_bad) begin
                    line_err <= 1'b1;
                end
                if (cls_emit) begin
                    tok_valid <= 1'b1;
                    tok_data  <= acc;
                    tok_last  <= cls_last;
                    tok_err   <= line_err;
                    tok_nodig <= (dig_cnt == 4'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_hex_line.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_uart_hex_line
//   Self-checking bench: rx/tx FIFO models, token consumer, and a string-level
//   reference model of the hex line protocol.
// ----------------------------------------------------------------------------
module tb_uart_hex_line;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_fifo_dvalid;
    logic [7:0]  rx_rdata;
    logic        rx_rden;
    logic        tx_fifo_full;
    logic [7:0]  tx_wdata;
    logic        tx_wten;
    logic [31:0] tok_data;
    logic        tok_valid;
    logic        tok_ready;
    logic        tok_last;
    logic        tok_err;
    logic        tok_nodig;

    uart_hex_line #(.ECHO_EN(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_fifo_dvalid (rx_fifo_dvalid),
        .rx_rdata       (rx_rdata),
        .rx_rden        (rx_rden),
        .tx_fifo_full   (tx_fifo_full),
        .tx_wdata       (tx_wdata),
        .tx_wten        (tx_wten),
        .tok_data       (tok_data),
        .tok_valid      (tok_valid),
        .tok_ready      (tok_ready),
        .tok_last       (tok_last),
        .tok_err        (tok_err),
        .tok_nodig      (tok_nodig)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
        logic        nodig;
    } tok_t;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [7:0]  exp_txq[$];
    tok_t        gotq[$];
    tok_t        expq[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    bit          pop_pending = 1'b0;

    // Reference model state
    logic [31:0] m_acc;
    int unsigned m_digits;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic void rx_refresh();
        rx_fifo_dvalid = (rxq.size() != 0);
        rx_rdata       = (rxq.size() != 0) ? rxq[0] : 8'h00;
    endfunction

    function automatic void model_reset();
        m_acc    = '0;
        m_digits = 0;
        m_err    = 1'b0;
    endfunction

    function automatic void model_emit(input bit last);
        tok_t t;
        t.data  = m_acc;
        t.last  = last;
        t.err   = m_err;
        t.nodig = (m_digits == 0);
        expq.push_back(t);
        m_acc    = '0;
        m_digits = 0;
        if (last) m_err = 1'b0;
    endfunction

    // Line protocol at string level: each byte is echoed (CR as CR LF); hex
    // digits build a base-16 number modulo 2^32; space/CR terminate tokens.
    function automatic void model_byte(input logic [7:0] b);
        int v;
        v = -1;
        exp_txq.push_back(b);
        if (b == 8'h0D) exp_txq.push_back(8'h0A);
        if (b >= 8'h30 && b <= 8'h39)      v = int'(b) - 48;
        else if (b >= 8'h41 && b <= 8'h46) v = int'(b) - 65 + 10;
        else if (b >= 8'h61 && b <= 8'h66) v = int'(b) - 97 + 10;
        if (v >= 0) begin
            m_acc    = m_acc * 32'd16 + 32'(v);
            m_digits = (m_digits < 8) ? m_digits + 1 : 8;
        end else if (b == 8'h20) begin
            if (m_digits > 0) model_emit(1'b0);
        end else if (b == 8'h0D) begin
            model_emit(1'b1);
        end else if (b == 8'h0A) begin
            // ignored
        end else begin
            m_err = 1'b1;
        end
    endfunction

    task automatic send_byte(input logic [7:0] b);
        rxq.push_back(b);
        model_byte(b);
        rx_refresh();
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // FIFO models and token consumer, sampled mid-cycle. An rx pop seen in
    // one cycle is applied at the next sample so the head byte stays put
    // across the edge that latches it.
    always @(negedge clk) begin
        if (!rst) begin
            if (pop_pending) begin
                if (rxq.size() != 0) void'(rxq.pop_front());
                pop_pending = 1'b0;
                rx_refresh();
            end
            if (rx_rden) begin
                check("rden_needs_dvalid", {31'd0, rx_fifo_dvalid}, 32'd1);
                pop_pending = 1'b1;
            end
            if (tx_wten) begin
                check("wten_while_full", {31'd0, tx_fifo_full}, 32'd0);
                txq.push_back(tx_wdata);
            end
            if (tok_valid && tok_ready) begin
                gotq.push_back({tok_data, tok_last, tok_err, tok_nodig});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input bit rand_bp);
        int unsigned cyc;
        cyc = 0;
        while ((rxq.size() != 0 || pop_pending) && cyc < 5000) begin
            tick();
            if (rand_bp) begin
                tx_fifo_full = ($urandom_range(0, 3) == 0);
                tok_ready    = ($urandom_range(0, 2) != 0);
            end
            cyc++;
        end
        check("drain_timeout", rxq.size(), 32'd0);
        tx_fifo_full = 1'b0;
        tok_ready    = 1'b1;
        repeat (12) tick();
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_ntok"}, gotq.size(), expq.size());
        for (int i = 0; i < gotq.size() && i < expq.size(); i++) begin
            check({tag, "_tok_data"},  gotq[i].data,           expq[i].data);
            check({tag, "_tok_last"},  {31'd0, gotq[i].last},  {31'd0, expq[i].last});
            check({tag, "_tok_err"},   {31'd0, gotq[i].err},   {31'd0, expq[i].err});
            check({tag, "_tok_nodig"}, {31'd0, gotq[i].nodig}, {31'd0, expq[i].nodig});
        end
        check({tag, "_necho"}, txq.size(), exp_txq.size());
        for (int i = 0; i < txq.size() && i < exp_txq.size(); i++) begin
            check({tag, "_echo"}, {24'd0, txq[i]}, {24'd0, exp_txq[i]});
        end
        gotq.delete();
        expq.delete();
        txq.delete();
        exp_txq.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rx_rden"},   {31'd0, rx_rden},   32'd0);
        check({tag, "_tx_wten"},   {31'd0, tx_wten},   32'd0);
        check({tag, "_tx_wdata"},  {24'd0, tx_wdata},  32'd0);
        check({tag, "_tok_valid"}, {31'd0, tok_valid}, 32'd0);
        check({tag, "_tok_data"},  tok_data,           32'd0);
        check({tag, "_tok_last"},  {31'd0, tok_last},  32'd0);
        check({tag, "_tok_err"},   {31'd0, tok_err},   32'd0);
        check({tag, "_tok_nodig"}, {31'd0, tok_nodig}, 32'd0);
    endtask

    function automatic logic [31:0] got_data(input int i);
        return (gotq.size() > i) ? gotq[i].data : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] got_flags(input int i);
        return (gotq.size() > i) ? {29'd0, gotq[i].last, gotq[i].err, gotq[i].nodig} : 32'hFFFF_FFFF;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned wcnt;
        int unsigned rcnt;
        int unsigned unstable;
        logic [31:0] held;
        string       hexchars;

        hexchars     = "0123456789abcdefABCDEF";
        rst          = 1'b1;
        tx_fifo_full = 1'b0;
        tok_ready    = 1'b1;
        model_reset();
        rx_refresh();

        // Reset: outputs quiet even with a byte waiting in the rx FIFO.
        rxq.push_back(8'h31);
        rx_refresh();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rxq.delete();
        rx_refresh();
        tick();
        rst = 1'b0;
        tick();

        // Single token with echo and CR LF.
        send("1a2B\r");
        drain(1'b0);
        check("t1_data", got_data(0), 32'h0000_1A2B);
        check("t1_flags", got_flags(0), 32'b100);
        check("t1_echo_count", txq.size(), 32'd6);
        compare_all("t1");

        // Space-separated tokens.
        send("12 34\r");
        drain(1'b0);
        check("t2_data0", got_data(0), 32'h12);
        check("t2_flags0", got_flags(0), 32'b000);
        check("t2_data1", got_data(1), 32'h34);
        check("t2_flags1", got_flags(1), 32'b100);
        compare_all("t2");

        // Nine digits: oldest digit shifted out.
        send("123456789\r");
        drain(1'b0);
        check("t3_data", got_data(0), 32'h2345_6789);
        compare_all("t3");

        // Illegal character sets err for that line only.
        send("1G\r5\r");
        drain(1'b0);
        check("t4_data0", got_data(0), 32'h1);
        check("t4_flags0", got_flags(0), 32'b110);
        check("t4_data1", got_data(1), 32'h5);
        check("t4_flags1", got_flags(1), 32'b100);
        compare_all("t4");

        // Minimum latency of a bare CR from an idle block.
        send("\r");
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (tok_valid) break;
        end
        check("latency_cr", n, 32'd5);
        check("latency_nodig", {31'd0, tok_nodig}, 32'd1);
        drain(1'b0);
        compare_all("t5");

        // tx FIFO full stall during echo.
        tx_fifo_full = 1'b1;
        send("7 8\r");
        repeat (10) tick();
        wcnt = 0;
        rcnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_wten) wcnt++;
            if (rx_rden) rcnt++;
        end
        check("stall_wten", wcnt, 32'd0);
        check("stall_rden", rcnt, 32'd0);
        check("stall_rx_left", rxq.size(), 32'd3);
        check("stall_no_echo", txq.size(), 32'd0);
        tick();
        tx_fifo_full = 1'b0;
        drain(1'b0);
        compare_all("t6");

        // Token backpressure, then reset mid-EMIT.
        tok_ready = 1'b0;
        send("AB 123");
        n = 0;
        while (!tok_valid && n < 50) begin
            tick();
            n++;
        end
        check("bp_valid", {31'd0, tok_valid}, 32'd1);
        check("bp_data", tok_data, 32'hAB);
        held     = tok_data;
        unstable = 0;
        rcnt     = 0;
        repeat (50) begin
            @(negedge clk);
            if (!tok_valid || tok_data !== held) unstable++;
            if (rx_rden) rcnt++;
        end
        check("bp_stable", unstable, 32'd0);
        check("bp_rden", rcnt, 32'd0);
        check("bp_rx_left", rxq.size(), 32'd3);
        tick();
        rst = 1'b1;
        #1;
        check_outputs_zero("midemit_rst");
        rxq.delete();
        pop_pending = 1'b0;
        rx_refresh();
        gotq.delete();
        expq.delete();
        txq.delete();
        exp_txq.delete();
        model_reset();
        repeat (3) tick();
        rst       = 1'b0;
        tok_ready = 1'b1;
        repeat (20) tick();
        check("rst_token_discarded", gotq.size(), 32'd0);
        check("rst_no_echo", txq.size(), 32'd0);

        // Randomized lines with random tx full and token backpressure.
        for (int batch = 0; batch < 8; batch++) begin
            int unsigned len;
            len = $urandom_range(4, 24);
            for (int k = 0; k < len; k++) begin
                int unsigned sel;
                logic [7:0]  b;
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1, 2, 3: b = hexchars[$urandom_range(0, 21)];
                    4, 5:       b = 8'h20;
                    6:          b = 8'h0D;
                    7:          b = 8'h0A;
                    8:          b = 8'($urandom_range(0, 255));
                    default:    b = 8'h67;
                endcase
                send_byte(b);
            end
            send_byte(8'h0D);
            drain(1'b1);
            compare_all("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_hex_line.md
UART_HEX_LINE -- requirements
Module: uart_hex_line

Interface
REQ-001 Parameter ECHO_EN, default 1, meaning: 1 echoes every received byte to the tx FIFO; 0 echoes nothing.
REQ-002 Port clk, input, 1, meaning: the single clock, rising edge.
REQ-003 Port rst, input, 1, meaning: reset, asynchronous and active-high.
REQ-004 Port rx_fifo_dvalid, input, 1, meaning: the rx FIFO holds at least one byte.
REQ-005 Port rx_rdata, input, 8, meaning: the byte at the rx FIFO head.
REQ-006 Port rx_rden, output, 1, meaning: one-cycle pop of the rx FIFO.
REQ-007 Port tx_fifo_full, input, 1, meaning: the tx FIFO cannot accept a byte.
REQ-008 Port tx_wdata, output, 8, meaning: the echo byte.
REQ-009 Port tx_wten, output, 1, meaning: one-cycle push to the tx FIFO.
REQ-010 Port tok_data, output, 32, meaning: the accumulated hex value.
REQ-011 Port tok_valid, output, 1, meaning: the token is presented.
REQ-012 Port tok_ready, input, 1, meaning: the consumer accepts the token.
REQ-013 Port tok_last, output, 1, meaning: the token ends a line (CR).
REQ-014 Port tok_err, output, 1, meaning: the line contained an illegal character.
REQ-015 Port tok_nodig, output, 1, meaning: the token carries no hex digits.

Function
REQ-016 The FSM states SHALL be IDLE, SETTLE, POP, ECHO, ECHO_LF and EMIT.
REQ-017 IDLE->SETTLE when rx_fifo_dvalid=1; SETTLE->POP unconditionally, giving one cycle for the RAM read to settle.
REQ-018 In POP: rx_rden=1 for exactly one cycle and rx_rdata latched into cur_byte; next state ECHO if ECHO_EN=1, else the classify step (REQ-023).
REQ-019 In ECHO: wait while tx_fifo_full=1; otherwise tx_wten=1 for one cycle with tx_wdata=cur_byte, then classify.
REQ-020 When cur_byte=0x0D and ECHO_EN=1, ECHO SHALL be followed by ECHO_LF, which pushes 0x0A under the same full rule before classifying.
REQ-021 The block SHALL never assert tx_wten while tx_fifo_full=1, and never assert rx_rden while rx_fifo_dvalid=0.
REQ-022 Hex digits are 0x30-0x39, 0x41-0x46 and 0x61-0x66, mapped to nibble values 0-15.
REQ-023 Classify, hex digit: acc <= {acc[27:0], nibble}; digit count increments, saturating at 8 (older digits shift out); next state IDLE.
REQ-024 Classify, space 0x20: if digit count>0, go to EMIT with tok_last=0; else IDLE with no token.
REQ-025 Classify, CR 0x0D: always go to EMIT with tok_last=1; tok_nodig=1 if digit count=0.
REQ-026 Classify, LF 0x0A: ignore, next state IDLE.
REQ-027 Classify, any other byte: set the sticky line error flag; next state IDLE.
REQ-028 In EMIT: tok_valid=1, with tok_data/tok_last/tok_err/tok_nodig held stable until tok_ready=1.
REQ-029 On the EMIT cycle with tok_ready=1: acc and digit count clear; the error flag clears only if tok_last=1; next state IDLE.
REQ-030 No rx byte SHALL be popped while in EMIT (backpressure into the rx FIFO).
REQ-031 Minimum latency from rx_fifo_dvalid rising to tok_valid on a CR: 5 cycles with ECHO_EN=1 and an empty tx FIFO (IDLE, SETTLE, POP, ECHO, ECHO_LF; tok_valid high in the next cycle).
REQ-032 tok_err SHALL be asserted on every token of a line once any illegal byte has been seen in that line.

Reset
REQ-033 While rst=1 the block SHALL hold state=IDLE and acc, digit count, error flag, cur_byte = 0.
REQ-034 While rst=1 all outputs SHALL be 0: rx_rden, tx_wten, tx_wdata, tok_valid, tok_data, tok_last, tok_err, tok_nodig.
REQ-035 Reset asserted mid-line or mid-EMIT SHALL discard the pending token and partial value without any further FIFO pop or push.

Structure
REQ-036 A shared package SHALL hold the state encoding (3 bits) and the constants ASCII_CR=0x0D, ASCII_LF=0x0A and ASCII_SP=0x20.
REQ-037 One combinational sub-module, hex_nibble_dec, SHALL be used: 8-bit in, 4-bit nibble out, plus is_hex.

Verification
REQ-038 Send "1a2B\r" with tok_ready=1 -> echo 31 61 32 42 0D 0A; one token tok_data=0x00001A2B, tok_last=1, tok_err=0, tok_nodig=0.
REQ-039 Send "12 34\r" -> two tokens: 0x12 with tok_last=0, then 0x34 with tok_last=1.
REQ-040 Send "123456789\r" -> tok_data=0x23456789 (saturation at 8 digits, oldest digit shifted out).
REQ-041 Send "1G\r" -> one token tok_data=0x1, tok_err=1, tok_last=1; a following "5\r" gives tok_err=0.
REQ-042 Hold tx_fifo_full=1 for 100 cycles during an echo -> no tx_wten and no rx_rden during the stall; echo completes on release.
REQ-043 Hold tok_ready=0 for 50 cycles with three bytes queued -> tok_data stable and rx_rden=0 throughout; assert rst mid-EMIT -> all outputs 0 and the token is never delivered.
